// File: rtl/symbol_depacketizer_pkg.sv
// Shared constants for the symbol depacketizer:
// mode codes, FSM encodings and header layout.
package symbol_depacketizer_pkg;

    localparam logic [3:0] MODE_BPSK = 4'b0001;
    localparam logic [3:0] MODE_QPSK = 4'b0010;
    localparam logic [3:0] MODE_MIX  = 4'b0100;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_TRN   = 3'd1;
    localparam logic [2:0] ST_HDR   = 3'd2;
    localparam logic [2:0] ST_PAD   = 3'd3;
    localparam logic [2:0] ST_PLD   = 3'd4;
    localparam logic [2:0] ST_FLUSH = 3'd5;

    // Header is MCS[7:0], length[15:0], signature[7:0], MSB first.
    localparam int HDR_BITS     = 32;
    localparam int HDR_LEN_LSB  = 8;
    localparam int HDR_SIG_LSB  = 0;
    // Arrival index of MCS[5] (BPSK payload flag) within the header.
    localparam int HDR_BPSK_POS = 2;

    localparam logic [7:0] DEF_SIGNATURE = 8'hA5;

    // Remove the barker phase ambiguity from one coded bit.
    function automatic logic sgn_fix(input logic b, input logic s);
        return ~(b ^ s);
    endfunction

endpackage

// File: rtl/symbol_depacketizer_if.sv
// AXI-Stream style output bundle of the depacketizer.
// Master drives data, slave drives ready.
interface symbol_depacketizer_if #(
    parameter int BYTES = 1
) ();

    logic [8*BYTES-1:0] data_tdata;
    logic               data_tvalid;
    logic               data_tready;
    logic               data_tlast;
    logic [BYTES-1:0]   data_tkeep;
    logic               data_tuser;

    modport master (
        output data_tdata, data_tvalid, data_tlast,
        output data_tkeep, data_tuser,
        input  data_tready
    );

    modport slave (
        input  data_tdata, data_tvalid, data_tlast,
        input  data_tkeep, data_tuser,
        output data_tready
    );

endinterface

// File: rtl/symbol_depacketizer_bit_packer.sv
// Serial 1/2-bit packer, MSB = earliest bit.
// Emits the word combinationally on the completing symbol.
module bit_packer #(
    parameter int BYTES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_valid,
    input  logic                 i_two,
    input  logic [1:0]           i_bits,
    input  logic                 i_last,
    output logic                 o_emit,
    output logic [8*BYTES-1:0]   o_word,
    output logic [BYTES-1:0]     o_keep
);

    localparam int BITS = 8 * BYTES;
    localparam int CW   = $clog2(BITS + 1) + 1;

    logic [BITS-1:0] r_word;
    logic [CW-1:0]   r_cnt;
    logic [BITS-1:0] w_ins;
    logic [CW-1:0]   w_cnt;
    logic [CW-1:0]   w_nbytes;

    assign w_ins = i_two ? {i_bits, {(BITS-2){1'b0}}}
                         : {i_bits[1], {(BITS-1){1'b0}}};
    assign w_cnt    = r_cnt + (i_two ? CW'(2) : CW'(1));
    assign w_nbytes = (w_cnt + CW'(7)) >> 3;
    assign o_word   = r_word | (w_ins >> r_cnt);
    assign o_emit   = i_valid && ((w_cnt == CW'(BITS)) || i_last);
    assign o_keep   = ~({BYTES{1'b1}} >> w_nbytes);

    // Accumulate bits; restart empty after every emitted word.
    always_ff @(posedge clk) begin
        if (rst || i_clr || o_emit) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_valid) begin
            r_word <= o_word;
            r_cnt  <= w_cnt;
        end
    end

endmodule

// File: rtl/symbol_depacketizer.sv
// Symbol depacketizer: raw BPSK/QPSK streaming or MIX
// packets (training, header, pad, payload) to AXI-Stream.
module symbol_depacketizer
    import symbol_depacketizer_pkg::*;
#(
    parameter int         BYTES            = 1,
    parameter int         MAX_WINDOW_WIDTH = 8,
    parameter int         TRN_LEN          = 31,
    parameter int         HDR_PAD          = 32,
    parameter logic [7:0] SIGNATURE        = DEF_SIGNATURE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MAX_WINDOW_WIDTH-1:0] RX_BD_WINDOW,
    input  logic [3:0]                  MODE_CTRL,
    input  logic                        BD_flag,
    input  logic                        BD_sgn,
    input  logic                        in_valid,
    input  logic [1:0]                  in_QPSK,
    input  logic                        in_BPSK,
    symbol_depacketizer_if.master       m_axis,
    output logic                        pkt_done,
    output logic                        hdr_err,
    output logic                        overflow
);

    localparam int         BITS     = 8 * BYTES;
    localparam logic [15:0] PAD_LAST = 16'(HDR_PAD - 1);

    logic [2:0]       r_state;
    logic [15:0]      r_cnt;
    logic [22:0]      r_hdr;
    logic [15:0]      r_rem;
    logic             r_sgn;
    logic             r_is_bpsk;
    logic [BITS-1:0]  r_tdata;
    logic [BYTES-1:0] r_tkeep;
    logic             r_tvalid;
    logic             r_tlast;
    logic             r_tuser;
    logic             r_pkt_done;
    logic             r_hdr_err;
    logic             r_ovf;

    logic             w_raw;
    logic             w_raw_bpsk;
    logic             w_start;
    logic             w_hbit;
    logic [1:0]       w_q;
    logic [23:0]      w_hdr;
    logic [15:0]      w_len;
    logic [7:0]       w_sig;
    logic signed [31:0] w_trn_need;
    logic             w_trn_done;
    logic             w_pk_valid;
    logic             w_pk_two;
    logic [1:0]       w_pk_bits;
    logic             w_pk_last;
    logic [15:0]      w_rem_next;
    logic             w_user;
    logic             w_emit;
    logic [BITS-1:0]  w_word;
    logic [BYTES-1:0] w_keep;

    assign w_raw_bpsk = (MODE_CTRL == MODE_BPSK);
    assign w_raw      = (r_state == ST_IDLE)
                     && (w_raw_bpsk || MODE_CTRL == MODE_QPSK);
    assign w_start    = (r_state == ST_IDLE) && BD_flag
                     && (MODE_CTRL == MODE_MIX);
    assign w_hbit     = sgn_fix(in_BPSK, r_sgn);
    assign w_q        = {sgn_fix(in_QPSK[1], r_sgn),
                         sgn_fix(in_QPSK[0], r_sgn)};
    assign w_hdr      = {r_hdr, w_hbit};
    assign w_len      = w_hdr[HDR_LEN_LSB +: 16];
    assign w_sig      = w_hdr[HDR_SIG_LSB +: 8];
    assign w_trn_need = TRN_LEN - 1 - int'(RX_BD_WINDOW);
    assign w_trn_done = (int'(r_cnt) + 1) >= w_trn_need;
    assign w_user     = (r_state == ST_IDLE) ? w_raw_bpsk : r_is_bpsk;

    // Select the bits fed to the packer for raw and payload symbols.
    always_comb begin
        w_pk_valid = 1'b0;
        w_pk_two   = 1'b0;
        w_pk_bits  = 2'b00;
        w_pk_last  = 1'b0;
        w_rem_next = r_rem;
        if (in_valid && w_raw) begin
            w_pk_valid = 1'b1;
            w_pk_two   = !w_raw_bpsk;
            w_pk_bits  = w_raw_bpsk ? {in_BPSK, 1'b0} : in_QPSK;
        end else if (in_valid && r_state == ST_PLD) begin
            w_pk_valid = 1'b1;
            w_pk_two   = !r_is_bpsk && (r_rem != 16'd1);
            w_pk_bits  = r_is_bpsk ? {w_hbit, 1'b0} : w_q;
            w_rem_next = r_rem - (w_pk_two ? 16'd2 : 16'd1);
            w_pk_last  = (w_rem_next == 16'd0);
        end
    end

    bit_packer #(.BYTES(BYTES)) u_packer (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_start),
        .i_valid (w_pk_valid),
        .i_two   (w_pk_two),
        .i_bits  (w_pk_bits),
        .i_last  (w_pk_last),
        .o_emit  (w_emit),
        .o_word  (w_word),
        .o_keep  (w_keep)
    );

    // Packet FSM: training, header decode, pad skip, payload, flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_hdr      <= '0;
            r_rem      <= '0;
            r_sgn      <= 1'b0;
            r_is_bpsk  <= 1'b0;
            r_pkt_done <= 1'b0;
            r_hdr_err  <= 1'b0;
        end else begin
            r_pkt_done <= 1'b0;
            r_hdr_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_TRN;
                        r_cnt   <= '0;
                    end
                end
                ST_TRN: begin
                    if (in_valid) begin
                        r_sgn <= BD_sgn;
                        if (w_trn_done) begin
                            r_state <= ST_HDR;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                ST_HDR: begin
                    if (in_valid) begin
                        r_hdr <= w_hdr[22:0];
                        if (r_cnt == 16'(HDR_BPSK_POS))
                            r_is_bpsk <= w_hbit;
                        if (r_cnt == 16'(HDR_BITS - 1)) begin
                            r_cnt <= '0;
                            r_rem <= w_len;
                            if (w_sig != SIGNATURE) begin
                                r_hdr_err  <= 1'b1;
                                r_pkt_done <= 1'b1;
                                r_state    <= ST_IDLE;
                            end else if (HDR_PAD != 0) begin
                                r_state <= ST_PAD;
                            end else if (w_len == 16'd0) begin
                                r_pkt_done <= 1'b1;
                                r_state    <= ST_IDLE;
                            end else begin
                                r_state <= ST_PLD;
                            end
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                ST_PAD: begin
                    if (in_valid) begin
                        if (r_cnt == PAD_LAST) begin
                            r_cnt <= '0;
                            if (r_rem == 16'd0) begin
                                r_pkt_done <= 1'b1;
                                r_state    <= ST_IDLE;
                            end else begin
                                r_state <= ST_PLD;
                            end
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                ST_PLD: begin
                    if (in_valid) begin
                        r_rem <= w_rem_next;
                        if (w_rem_next == 16'd0)
                            r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (!r_tvalid || m_axis.data_tready) begin
                        r_pkt_done <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Single-entry output register; a word arriving while stalled is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tuser  <= 1'b1;
            r_ovf    <= 1'b0;
        end else if (w_emit) begin
            if (r_tvalid && !m_axis.data_tready) begin
                r_ovf <= 1'b1;
            end else begin
                r_tdata  <= w_word;
                r_tkeep  <= w_keep;
                r_tvalid <= 1'b1;
                r_tlast  <= w_pk_last;
                r_tuser  <= w_user;
            end
        end else if (m_axis.data_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign m_axis.data_tdata  = r_tdata;
    assign m_axis.data_tkeep  = r_tkeep;
    assign m_axis.data_tvalid = r_tvalid;
    assign m_axis.data_tlast  = r_tlast;
    assign m_axis.data_tuser  = r_tuser;
    assign pkt_done           = r_pkt_done;
    assign hdr_err            = r_hdr_err;
    assign overflow           = r_ovf;

endmodule

// File: tb/tb_symbol_depacketizer.sv
// Bench for symbol_depacketizer: one BYTES=1 and one BYTES=2
// instance on shared symbol inputs, scoreboarded output words.
module tb_symbol_depacketizer;

    localparam int TRN_LEN = 31;
    localparam int HDR_PAD = 32;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  k;
        logic        l;
        logic        u;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] win = 8'd8;
    logic [3:0] mode = 4'b0100;
    logic       bd = 1'b0;
    logic       sgn = 1'b0;
    logic       vld = 1'b0;
    logic       bpsk = 1'b0;
    logic [1:0] qpsk = 2'b00;
    logic       rdy1 = 1'b1;
    logic       rdy2 = 1'b1;
    int         sel = 0;
    int         gap = 0;

    logic v1, v2, bd1, bd2;
    logic pd1, he1, ov1, pd2, he2, ov2;

    int checks = 0;
    int passes = 0;
    int pdc1 = 0;
    int pdc2 = 0;
    int hec1 = 0;
    int exp_pd1 = 0;
    int exp_pd2 = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;

    always #5 clk = ~clk;

    assign v1  = vld && (sel == 0);
    assign v2  = vld && (sel == 1);
    assign bd1 = bd && (sel == 0);
    assign bd2 = bd && (sel == 1);

    symbol_depacketizer_if #(.BYTES(1)) ax1 ();
    symbol_depacketizer_if #(.BYTES(2)) ax2 ();

    assign ax1.data_tready = rdy1;
    assign ax2.data_tready = rdy2;

    symbol_depacketizer #(
        .BYTES(1), .MAX_WINDOW_WIDTH(8), .TRN_LEN(TRN_LEN),
        .HDR_PAD(HDR_PAD), .SIGNATURE(8'hA5)
    ) u1 (
        .clk(clk), .rst(rst), .RX_BD_WINDOW(win), .MODE_CTRL(mode),
        .BD_flag(bd1), .BD_sgn(sgn), .in_valid(v1), .in_QPSK(qpsk),
        .in_BPSK(bpsk), .m_axis(ax1), .pkt_done(pd1), .hdr_err(he1),
        .overflow(ov1)
    );

    symbol_depacketizer #(
        .BYTES(2), .MAX_WINDOW_WIDTH(8), .TRN_LEN(TRN_LEN),
        .HDR_PAD(HDR_PAD), .SIGNATURE(8'hA5)
    ) u2 (
        .clk(clk), .rst(rst), .RX_BD_WINDOW(win), .MODE_CTRL(mode),
        .BD_flag(bd2), .BD_sgn(sgn), .in_valid(v2), .in_QPSK(qpsk),
        .in_BPSK(bpsk), .m_axis(ax2), .pkt_done(pd2), .hdr_err(he2),
        .overflow(ov2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Monitor: count pulses, pop and compare every accepted word.
    always @(negedge clk) begin
        if (pd1) pdc1++;
        if (pd2) pdc2++;
        if (he1) hec1++;
        if (ax1.data_tvalid && ax1.data_tready) begin
            if (q1.size() == 0) begin
                chk("w1_unexpected", 32'(q1.size()), 32'd1);
            end else begin
                e1 = q1.pop_front();
                chk("w1_data", {24'd0, ax1.data_tdata}, {16'd0, e1.d});
                chk("w1_keep", {31'd0, ax1.data_tkeep}, {30'd0, e1.k});
                chk("w1_last", {31'd0, ax1.data_tlast}, {31'd0, e1.l});
                chk("w1_user", {31'd0, ax1.data_tuser}, {31'd0, e1.u});
            end
        end
        if (ax2.data_tvalid && ax2.data_tready) begin
            if (q2.size() == 0) begin
                chk("w2_unexpected", 32'(q2.size()), 32'd1);
            end else begin
                e2 = q2.pop_front();
                chk("w2_data", {16'd0, ax2.data_tdata}, {16'd0, e2.d});
                chk("w2_keep", {30'd0, ax2.data_tkeep}, {30'd0, e2.k});
                chk("w2_last", {31'd0, ax2.data_tlast}, {31'd0, e2.l});
                chk("w2_user", {31'd0, ax2.data_tuser}, {31'd0, e2.u});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sym(input logic b, input logic [1:0] q);
        vld  = 1'b1;
        bpsk = b;
        qpsk = q;
        tick();
        vld = 1'b0;
        if (gap != 0) tick();
    endtask

    task automatic send_bit(input logic b);
        sym(~(b ^ sgn), 2'b00);
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
    endtask

    task automatic send_q(input logic [1:0] b);
        sym(1'b0, {~(b[1] ^ sgn), ~(b[0] ^ sgn)});
    endtask

    task automatic push1(input logic [7:0] d, input logic l,
                         input logic u);
        exp_t e;
        e.d = {8'd0, d};
        e.k = 2'b01;
        e.l = l;
        e.u = u;
        q1.push_back(e);
    endtask

    task automatic push2(input logic [15:0] d, input logic [1:0] k,
                         input logic l, input logic u);
        exp_t e;
        e.d = d;
        e.k = k;
        e.l = l;
        e.u = u;
        q2.push_back(e);
    endtask

    task automatic start_pkt(input int s, input logic [7:0] mcs,
                             input logic [15:0] len,
                             input logic [7:0] sig, input bit pad);
        int n;
        logic [31:0] h;
        sel = s;
        bd  = 1'b1;
        tick();
        bd = 1'b0;
        n = TRN_LEN - 1 - int'(win);
        if (n < 1) n = 1;
        for (int i = 0; i < n; i++) sym(1'b1, 2'b11);
        h = {mcs, len, sig};
        for (int i = 31; i >= 0; i--) send_bit(h[i]);
        if (pad) for (int i = 0; i < HDR_PAD; i++) sym(1'b0, 2'b00);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (q1.size() + q2.size()) > 0; i++)
            tick();
        repeat (3) tick();
        chk("drain", 32'(q1.size() + q2.size()), 32'd0);
    endtask

    initial begin
        logic [19:0] p;
        logic [15:0] r;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_tvalid", {31'd0, ax1.data_tvalid}, 32'd0);
        chk("rst_tdata", {24'd0, ax1.data_tdata}, 32'd0);
        chk("rst_tkeep", {31'd0, ax1.data_tkeep}, 32'd0);
        chk("rst_tlast", {31'd0, ax1.data_tlast}, 32'd0);
        chk("rst_tuser", {31'd0, ax1.data_tuser}, 32'd1);
        chk("rst_tuser2", {31'd0, ax2.data_tuser}, 32'd1);
        chk("rst_pkt_done", {31'd0, pd1}, 32'd0);
        chk("rst_hdr_err", {31'd0, he1}, 32'd0);
        chk("rst_overflow", {31'd0, ov1}, 32'd0);
        rst = 1'b0;
        tick();

        // BPSK packet, BD_sgn=0, 22 training symbols
        mode = 4'b0100;
        sgn  = 1'b0;
        win  = 8'd8;
        push1(8'h3C, 1'b0, 1'b1);
        push1(8'h5A, 1'b1, 1'b1);
        start_pkt(0, 8'h20, 16'd16, 8'hA5, 1'b1);
        send_byte(8'h3C);
        send_byte(8'h5A);
        drain();
        exp_pd1++;
        chk("pd_bpsk_sgn0", 32'(pdc1), 32'(exp_pd1));

        // Same with inverted phase, single training symbol
        sgn = 1'b1;
        win = 8'd30;
        push1(8'h3C, 1'b0, 1'b1);
        push1(8'h5A, 1'b1, 1'b1);
        start_pkt(0, 8'h20, 16'd16, 8'hA5, 1'b1);
        send_byte(8'h3C);
        send_byte(8'h5A);
        drain();
        exp_pd1++;
        chk("pd_bpsk_sgn1", 32'(pdc1), 32'(exp_pd1));

        // BYTES=2 QPSK, 20 bits: full word then 4-bit tail
        sgn = 1'b0;
        p = 20'hA5C3B;
        push2(16'hA5C3, 2'b11, 1'b0, 1'b0);
        push2(16'hB000, 2'b10, 1'b1, 1'b0);
        start_pkt(1, 8'h00, 16'd20, 8'hA5, 1'b1);
        for (int i = 19; i > 0; i -= 2) send_q(p[i -: 2]);
        drain();
        exp_pd2++;
        chk("pd_qpsk20", 32'(pdc2), 32'(exp_pd2));

        // QPSK odd length: last symbol gives bit1 only
        push2(16'hA000, 2'b10, 1'b1, 1'b0);
        start_pkt(1, 8'h00, 16'd3, 8'hA5, 1'b1);
        send_q(2'b10);
        send_q(2'b10);
        drain();
        exp_pd2++;
        chk("pd_qpsk_odd", 32'(pdc2), 32'(exp_pd2));

        // Bad signature: hdr_err + pkt_done, no word
        start_pkt(0, 8'h20, 16'd16, 8'h00, 1'b0);
        repeat (3) tick();
        exp_pd1++;
        chk("hdr_err_cnt", 32'(hec1), 32'd1);
        chk("pd_hdr_err", 32'(pdc1), 32'(exp_pd1));
        chk("hdr_err_tvalid", {31'd0, ax1.data_tvalid}, 32'd0);
        push1(8'h3C, 1'b0, 1'b1);
        push1(8'h5A, 1'b1, 1'b1);
        start_pkt(0, 8'h20, 16'd16, 8'hA5, 1'b1);
        send_byte(8'h3C);
        send_byte(8'h5A);
        drain();
        exp_pd1++;
        chk("pd_after_err", 32'(pdc1), 32'(exp_pd1));

        // Stall across two word completions: second word dropped
        rdy1 = 1'b0;
        push1(8'h11, 1'b0, 1'b1);
        start_pkt(0, 8'h20, 16'd16, 8'hA5, 1'b1);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (2) tick();
        chk("ovf_set", {31'd0, ov1}, 32'd1);
        chk("ovf_hold_valid", {31'd0, ax1.data_tvalid}, 32'd1);
        chk("ovf_hold_data", {24'd0, ax1.data_tdata}, 32'h11);
        rdy1 = 1'b1;
        drain();
        exp_pd1++;
        chk("pd_ovf", 32'(pdc1), 32'(exp_pd1));
        chk("ovf_sticky", {31'd0, ov1}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ovf_cleared", {31'd0, ov1}, 32'd0);

        // Reset mid-payload with 50% gated symbols
        gap  = 1;
        rdy1 = 1'b0;
        start_pkt(0, 8'h20, 16'd16, 8'hA5, 1'b1);
        send_byte(8'h77);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        chk("pre_rst_valid", {31'd0, ax1.data_tvalid}, 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", {31'd0, ax1.data_tvalid}, 32'd0);
        chk("mid_rst_data", {24'd0, ax1.data_tdata}, 32'd0);
        rst  = 1'b0;
        rdy1 = 1'b1;
        repeat (2) tick();
        chk("pd_no_abort", 32'(pdc1), 32'(exp_pd1));
        push1(8'h3C, 1'b0, 1'b1);
        push1(8'h5A, 1'b1, 1'b1);
        start_pkt(0, 8'h20, 16'd16, 8'hA5, 1'b1);
        send_byte(8'h3C);
        send_byte(8'h5A);
        drain();
        exp_pd1++;
        chk("pd_after_rst", 32'(pdc1), 32'(exp_pd1));
        gap = 0;

        // Raw BPSK on BYTES=2, raw QPSK on BYTES=1
        mode = 4'b0001;
        sel  = 1;
        r    = 16'h9C35;
        push2(16'h9C35, 2'b11, 1'b0, 1'b1);
        for (int i = 15; i >= 0; i--) sym(r[i], 2'b00);
        mode = 4'b0010;
        sel  = 0;
        push1(8'hE4, 1'b0, 1'b0);
        sym(1'b0, 2'b11);
        sym(1'b0, 2'b10);
        sym(1'b0, 2'b01);
        sym(1'b0, 2'b00);
        drain();
        chk("raw_no_pd", 32'(pdc1 + pdc2), 32'(exp_pd1 + exp_pd2));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
